register_bank_dual_write: RTL and testbench

Parametrised successor to the single-write CPU register bank. Provides three asynchronous read ports and two synchronous write ports, with an optional hard-wired zero register (ARM XZR/X31 style). Includes same-cycle write-to-read bypass and a per-register busy scoreboard for pipeline hazard detection. Sits between decode (reads, reserve) and writeback (two retiring results per cycle).

---
 rtl/register_bank_dual_write.sv | 148 ++++++++++++++
 tb/tb_register_bank_dual_write.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_bank_dual_write.sv
// Dual-write CPU register bank with a pending-result scoreboard.
//
// Purpose:
//   Holds 2**ADDR_WIDTH registers of DATA_WIDTH bits. Decode reads three operands
//   combinationally and reserves the destination of an issuing instruction;
//   writeback retires up to two results per cycle. An optional hard-wired zero
//   register and same-cycle write-to-read bypass are selectable by parameter.
//
// Ports:
//   clock, reset                 rising-edge clock, asynchronous active-high reset
//   read_address_N / read_data_N three combinational read ports (N = 1..3)
//   busy_N                       scoreboard bit for read_address_N
//   write_N, write_address_N,
//   write_data_N                 two synchronous write ports (N = 1..2)
//   reserve, reserve_address     mark a register as having a result pending
module register_bank_dual_write #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter bit          ZERO_REG_EN = 1'b1,
    parameter int unsigned ZERO_INDEX  = 31,
    parameter bit          BYPASS_EN   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_address_1,
    input  logic [ADDR_WIDTH-1:0] read_address_2,
    input  logic [ADDR_WIDTH-1:0] read_address_3,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic [DATA_WIDTH-1:0] read_data_3,
    output logic                  busy_1,
    output logic                  busy_2,
    output logic                  busy_3,
    input  logic                  write_1,
    input  logic [ADDR_WIDTH-1:0] write_address_1,
    input  logic [DATA_WIDTH-1:0] write_data_1,
    input  logic                  write_2,
    input  logic [ADDR_WIDTH-1:0] write_address_2,
    input  logic [DATA_WIDTH-1:0] write_data_2,
    input  logic                  reserve,
    input  logic [ADDR_WIDTH-1:0] reserve_address
);

    localparam int unsigned           DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_INDEX);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;

    logic                  wr1_en;
    logic                  wr2_en;
    logic                  res_en;

    logic [ADDR_WIDTH-1:0] rd_addr [3];
    logic [DATA_WIDTH-1:0] rd_data [3];
    logic [2:0]            rd_busy;

    // ------------------------------------------------------------------
    // Effective write/reserve enables
    // ------------------------------------------------------------------
    always_comb begin
        wr1_en = write_1;
        wr2_en = write_2;
        res_en = reserve;
        if (ZERO_REG_EN) begin
            if (write_address_1 == ZERO_ADDR) wr1_en = 1'b0;
            if (write_address_2 == ZERO_ADDR) wr2_en = 1'b0;
            if (reserve_address == ZERO_ADDR) res_en = 1'b0;
        end
        // Collision: port 2 owns the address, port 1 is dropped entirely.
        if (write_2 && (write_address_1 == write_address_2)) wr1_en = 1'b0;
    end

    // ------------------------------------------------------------------
    // Register storage
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (wr1_en) regs_q[write_address_1] <= write_data_1;
            if (wr2_en) regs_q[write_address_2] <= write_data_2;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (wr1_en) busy_d[write_address_1] = 1'b0;
        if (wr2_en) busy_d[write_address_2] = 1'b0;
        // Applied last: a new producer issuing as the old one retires keeps it busy.
        if (res_en) busy_d[reserve_address] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    assign rd_addr[0] = read_address_1;
    assign rd_addr[1] = read_address_2;
    assign rd_addr[2] = read_address_3;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            rd_busy[p] = busy_q[rd_addr[p]];
            if (BYPASS_EN) begin
                // Port 2 checked second so it takes priority on a collision.
                if (write_1 && (write_address_1 == rd_addr[p])) rd_data[p] = write_data_1;
                if (write_2 && (write_address_2 == rd_addr[p])) rd_data[p] = write_data_2;
                if (((write_1 && (write_address_1 == rd_addr[p])) ||
                     (write_2 && (write_address_2 == rd_addr[p]))) &&
                    !(reserve && (reserve_address == rd_addr[p]))) begin
                    rd_busy[p] = 1'b0;
                end
            end
            if (ZERO_REG_EN && (rd_addr[p] == ZERO_ADDR)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
            // Storage is already clear under reset; this also masks the bypass path.
            if (reset) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign read_data_1 = rd_data[0];
    assign read_data_2 = rd_data[1];
    assign read_data_3 = rd_data[2];
    assign busy_1      = rd_busy[0];
    assign busy_2      = rd_busy[1];
    assign busy_3      = rd_busy[2];

endmodule

// File: tb/tb_register_bank_dual_write.sv
module tb_register_bank_dual_write;

    logic        clock;
    logic        reset;
    logic [4:0]  ra [3];
    logic        w1, w2, res;
    logic [4:0]  wa1, wa2, resa;
    logic [63:0] wd1, wd2;

    logic [63:0] rd_a [3];
    logic [63:0] rd_b [3];
    logic        busy_a [3];
    logic        busy_b [3];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [63:0] mem [32];
    bit          sb  [32];

    // DUT A: bypass on (defaults). DUT B: bypass off. Same inputs.
    register_bank_dual_write dut_a (
        .clock           (clock),
        .reset           (reset),
        .read_address_1  (ra[0]),
        .read_address_2  (ra[1]),
        .read_address_3  (ra[2]),
        .read_data_1     (rd_a[0]),
        .read_data_2     (rd_a[1]),
        .read_data_3     (rd_a[2]),
        .busy_1          (busy_a[0]),
        .busy_2          (busy_a[1]),
        .busy_3          (busy_a[2]),
        .write_1         (w1),
        .write_address_1 (wa1),
        .write_data_1    (wd1),
        .write_2         (w2),
        .write_address_2 (wa2),
        .write_data_2    (wd2),
        .reserve         (res),
        .reserve_address (resa)
    );

    register_bank_dual_write #(
        .BYPASS_EN (1'b0)
    ) dut_b (
        .clock           (clock),
        .reset           (reset),
        .read_address_1  (ra[0]),
        .read_address_2  (ra[1]),
        .read_address_3  (ra[2]),
        .read_data_1     (rd_b[0]),
        .read_data_2     (rd_b[1]),
        .read_data_3     (rd_b[2]),
        .busy_1          (busy_b[0]),
        .busy_2          (busy_b[1]),
        .busy_3          (busy_b[2]),
        .write_1         (w1),
        .write_address_1 (wa1),
        .write_data_1    (wd1),
        .write_2         (w2),
        .write_address_2 (wa2),
        .write_data_2    (wd2),
        .reserve         (res),
        .reserve_address (resa)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            sb[i]  = 1'b0;
        end
    endtask

    // Commit what the bank should do at the coming edge, given current inputs.
    task automatic model_commit();
        if (w1 && wa1 != 5'd31 && !(w2 && wa2 == wa1)) mem[wa1] = wd1;
        if (w2 && wa2 != 5'd31) mem[wa2] = wd2;
        if (w1 && wa1 != 5'd31) sb[wa1] = 1'b0;
        if (w2 && wa2 != 5'd31) sb[wa2] = 1'b0;
        if (res && resa != 5'd31) sb[resa] = 1'b1;
    endtask

    function automatic logic [63:0] exp_read(logic [4:0] a, bit byp);
        if (a == 5'd31) return 64'd0;
        if (byp && w2 && a == wa2) return wd2;
        if (byp && w1 && a == wa1) return wd1;
        return mem[a];
    endfunction

    function automatic bit exp_busy(logic [4:0] a, bit byp);
        if (a == 5'd31) return 1'b0;
        if (byp && ((w1 && a == wa1) || (w2 && a == wa2)) && !(res && a == resa)) return 1'b0;
        return sb[a];
    endfunction

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        w1 = 1'b0; wa1 = '0; wd1 = '0;
        w2 = 1'b0; wa2 = '0; wd2 = '0;
        res = 1'b0; resa = '0;
    endtask

    task automatic step();
        model_commit();
        @(posedge clock);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_power_on();
        reset = 1'b1;
        idle_inputs();
        ra[0] = 5'd0; ra[1] = 5'd1; ra[2] = 5'd2;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (rd_a[p] !== 64'd0 || busy_a[p] !== 1'b0) begin
                n_fail++;
                $display("FAIL power_on port%0d: data=%h busy=%b, expected 0/0", p, rd_a[p], busy_a[p]);
            end
        end
    endtask

    task automatic test_dual_write();
        w1 = 1'b1; wa1 = 5'd3; wd1 = 64'h1111;
        w2 = 1'b1; wa2 = 5'd4; wd2 = 64'h2222;
        ra[0] = 5'd3; ra[1] = 5'd4;
        #1;
        n_checks++;
        if (rd_a[0] !== 64'h1111 || rd_b[0] !== 64'h0) begin
            n_fail++;
            $display("FAIL dual_write_bypass: a=%h b=%h, expected 1111/0", rd_a[0], rd_b[0]);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_a[0] !== 64'h1111 || rd_a[1] !== 64'h2222 ||
            rd_b[0] !== 64'h1111 || rd_b[1] !== 64'h2222) begin
            n_fail++;
            $display("FAIL dual_write: r3=%h/%h r4=%h/%h, expected 1111/2222",
                     rd_a[0], rd_b[0], rd_a[1], rd_b[1]);
        end
    endtask

    task automatic test_collision();
        w1 = 1'b1; wa1 = 5'd7; wd1 = 64'hAAAA;
        w2 = 1'b1; wa2 = 5'd7; wd2 = 64'hBBBB;
        ra[0] = 5'd7;
        #1;
        n_checks++;
        if (rd_a[0] !== 64'hBBBB) begin
            n_fail++;
            $display("FAIL collision_bypass: got %h, expected bbbb", rd_a[0]);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_a[0] !== 64'hBBBB || rd_b[0] !== 64'hBBBB) begin
            n_fail++;
            $display("FAIL collision_store: a=%h b=%h, expected bbbb", rd_a[0], rd_b[0]);
        end
    endtask

    task automatic test_zero_reg();
        w1 = 1'b1; wa1 = 5'd31; wd1 = 64'hFFFF;
        res = 1'b1; resa = 5'd31;
        ra[0] = 5'd31;
        #1;
        n_checks++;
        if (rd_a[0] !== 64'd0 || rd_b[0] !== 64'd0 || busy_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_same_cycle: a=%h b=%h busy=%b, expected 0", rd_a[0], rd_b[0], busy_a[0]);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_a[0] !== 64'd0 || rd_b[0] !== 64'd0 || busy_a[0] !== 1'b0 || busy_b[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_next_cycle: a=%h b=%h busy=%b/%b, expected 0",
                     rd_a[0], rd_b[0], busy_a[0], busy_b[0]);
        end
    endtask

    task automatic test_scoreboard();
        res = 1'b1; resa = 5'd5;
        ra[0] = 5'd5;
        #1;
        n_checks++;
        if (busy_a[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_before_edge: busy=%b, expected 0", busy_a[0]);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (busy_a[0] !== 1'b1 || busy_b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_reserved: busy=%b/%b, expected 1/1", busy_a[0], busy_b[0]);
        end
        w1 = 1'b1; wa1 = 5'd5; wd1 = 64'h5555;
        #1;
        n_checks++;
        if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_write_cycle: busy=%b/%b, expected 0/1", busy_a[0], busy_b[0]);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (busy_a[0] !== 1'b0 || busy_b[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_cleared: busy=%b/%b, expected 0/0", busy_a[0], busy_b[0]);
        end
        res = 1'b1; resa = 5'd5;
        step();
        w1 = 1'b1; wa1 = 5'd5; wd1 = 64'h6666;
        #1;
        n_checks++;
        if (busy_a[0] !== 1'b1 || busy_b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_reserve_and_write: busy=%b/%b, expected 1/1", busy_a[0], busy_b[0]);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (busy_a[0] !== 1'b1 || busy_b[0] !== 1'b1 || rd_a[0] !== 64'h6666) begin
            n_fail++;
            $display("FAIL sb_reserve_wins: busy=%b/%b data=%h, expected 1/1 6666",
                     busy_a[0], busy_b[0], rd_a[0]);
        end
    endtask

    task automatic test_no_bypass();
        w1 = 1'b1; wa1 = 5'd2; wd1 = 64'h10;
        step();
        w1 = 1'b1; wa1 = 5'd2; wd1 = 64'h55;
        ra[0] = 5'd2;
        #1;
        n_checks++;
        if (rd_b[0] !== 64'h10 || rd_a[0] !== 64'h55) begin
            n_fail++;
            $display("FAIL no_bypass_before: b=%h a=%h, expected 10/55", rd_b[0], rd_a[0]);
        end
        step();
        idle_inputs();
        #1;
        n_checks++;
        if (rd_b[0] !== 64'h55) begin
            n_fail++;
            $display("FAIL no_bypass_after: b=%h, expected 55", rd_b[0]);
        end
    endtask

    function automatic logic [4:0] rand_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'd31;
        if (r == 1) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            w1   = 1'($urandom_range(0, 1));
            w2   = 1'($urandom_range(0, 1));
            res  = 1'($urandom_range(0, 2) == 0);
            wa1  = rand_addr();
            wa2  = ($urandom_range(0, 4) == 0) ? wa1 : rand_addr();
            resa = ($urandom_range(0, 3) == 0) ? wa1 : rand_addr();
            wd1  = {$urandom, $urandom};
            wd2  = {$urandom, $urandom};
            for (int p = 0; p < 3; p++) begin
                case ($urandom_range(0, 3))
                    0: ra[p] = wa1;
                    1: ra[p] = wa2;
                    default: ra[p] = rand_addr();
                endcase
            end
            #1;
            for (int p = 0; p < 3; p++) begin
                n_checks++;
                if (rd_a[p] !== exp_read(ra[p], 1'b1) || rd_b[p] !== exp_read(ra[p], 1'b0) ||
                    busy_a[p] !== exp_busy(ra[p], 1'b1) || busy_b[p] !== exp_busy(ra[p], 1'b0)) begin
                    n_fail++;
                    $display("FAIL random cyc%0d port%0d addr%0d: data=%h/%h busy=%b/%b, expected %h/%h %b/%b",
                             cyc, p, ra[p], rd_a[p], rd_b[p], busy_a[p], busy_b[p],
                             exp_read(ra[p], 1'b1), exp_read(ra[p], 1'b0),
                             exp_busy(ra[p], 1'b1), exp_busy(ra[p], 1'b0));
                end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        w1 = 1'b1; wa1 = 5'd9; wd1 = 64'hDEAD_BEEF_0000_0009;
        res = 1'b1; resa = 5'd12;
        step();
        res = 1'b0;
        wd1 = 64'h1234_5678_9ABC_DEF0;
        ra[0] = 5'd9; ra[1] = 5'd12; ra[2] = 5'd7;
        #1;
        reset = 1'b1;
        #1;
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (rd_a[p] !== 64'd0 || rd_b[p] !== 64'd0 || busy_a[p] !== 1'b0 || busy_b[p] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_async port%0d: data=%h/%h busy=%b/%b, expected 0",
                         p, rd_a[p], rd_b[p], busy_a[p], busy_b[p]);
            end
        end
        @(posedge clock);
        #1;
        idle_inputs();
        reset = 1'b0;
        model_clear();
        #1;
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (rd_b[p] !== 64'd0 || busy_b[p] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release port%0d: data=%h busy=%b, expected 0", p, rd_b[p], busy_b[p]);
            end
        end
    endtask

    initial begin
        idle_inputs();
        ra[0] = '0; ra[1] = '0; ra[2] = '0;
        test_power_on();
        test_dual_write();
        test_collision();
        test_zero_reg();
        test_scoreboard();
        test_no_bypass();
        test_random();
        test_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
